alu_ctrl_issue_stage: RTL
=========================

// Module: alu_ctrl_issue_stage
// PURPOSE
//  Decode/issue side of the execute-stage ALU: decodes the instruction in ID into a 3-bit
//  ALUControl and control bits, builds SrcA/SrcB (sign-extended immediate or register), and
//  registers everything into the ID/EX pipeline register, with stall (hold) and flush (bubble).
//  The EX-stage ALU consumes SrcAE/SrcBE/ALUControlE directly, with no further decode.
// PARAMETERS
//  WIDTH   32   datapath width (SrcA/SrcB/RD1/RD2/immediate); must be >= 16
// PORTS
//  CLK          in   1      rising-edge clock, sole clock
//  RST          in   1      synchronous, active-high reset
//  StallE       in   1      hold ID/EX register contents
//  FlushE       in   1      load a bubble (all control zero) into ID/EX
//  InstrD       in   32     instruction in ID
//  RD1D         in   WIDTH  register file read data, rs
//  RD2D         in   WIDTH  register file read data, rt
//  SrcAE        out  WIDTH  ALU operand A (= RD1 of issued instr)
//  SrcBE        out  WIDTH  ALU operand B (RD2 or sign-extended imm16)
//  WriteDataE   out  WIDTH  store data (= RD2 of issued instr)
//  ALUControlE  out  3      000 AND, 001 OR, 010 ADD, 100 SUB, 101 MUL, 110 SLT
//  RegWriteE    out  1      instruction writes register file
//  MemtoRegE    out  1      writeback selects memory data
//  MemWriteE    out  1      store
//  BranchE      out  1      beq
//  WriteRegE    out  5      destination register (rd for R-type, rt for I-type)
//  ValidE       out  1      ID/EX holds a real instruction (0 = bubble)
//  IllegalE     out  1      issued opcode/funct not decodable
// BEHAVIOUR
//  Decode (combinational, on InstrD; op=[31:26], funct=[5:0]):
//   - op 000000: funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 011000 MUL;
//     RegWrite=1, SrcB=RD2, WriteReg=rd[15:11]
//   - op 100011 lw: ADD, SrcB=imm, RegWrite=1, MemtoReg=1, WriteReg=rt[20:16]
//   - op 101011 sw: ADD, SrcB=imm, MemWrite=1, RegWrite=0
//   - op 001000 addi: ADD, SrcB=imm, RegWrite=1, WriteReg=rt
//   - op 000100 beq: SUB, SrcB=RD2, Branch=1, RegWrite=0
//   - any other op, or R-type with any other funct: Illegal=1, ALUControl=000,
//     RegWrite/MemWrite/MemtoReg/Branch all 0, Valid=1
//   - imm = {{(WIDTH-16){InstrD[15]}}, InstrD[15:0]} (sign extension, never zero extension)
//   - InstrD = 32'h0000_0000 (sll $0 nop) has funct 000000, so it decodes as illegal R-type;
//     the same rule applies to every undecoded funct.
//  Register update at posedge CLK, priority RST > FlushE > StallE > load:
//   - RST: every output 0 (ValidE=0, ALUControlE=000, SrcAE/SrcBE/WriteDataE=0, WriteRegE=0)
//   - FlushE (StallE ignored when both high): every output 0, identical to reset
//   - StallE only: all outputs hold their previous values
//   - else: load decoded values; ValidE=1
//  Latency: InstrD/RD1D/RD2D sampled at edge N appear on E outputs after edge N, i.e. 1 cycle.
//  No combinational path from any input to any output.
//  RST asserted mid-stream discards the in-flight instruction; the first load happens on the
//  first edge after RST deasserts.
// TESTING
//  1 RST=1 for 2 cycles with random inputs -> all outputs 0, ValidE=0.
//  2 InstrD=32'h0022_1820 (add $3,$1,$2), RD1D=5, RD2D=7 -> next cycle SrcAE=5, SrcBE=7,
//    ALUControlE=010, RegWriteE=1, WriteRegE=3, ValidE=1.
//  3 InstrD=32'h8C22_FFFC (lw $2,-4($1)), RD1D=100 -> SrcBE=32'hFFFF_FFFC, ALUControlE=010,
//    MemtoRegE=1, WriteRegE=2; then beq 32'h1022_0003 -> ALUControlE=100, BranchE=1, RegWriteE=0.
//  4 Issue add, then StallE=1 for 3 cycles while InstrD changes to sub -> outputs stay at the
//    add values; StallE=0 -> sub (ALUControlE=100) appears the next cycle.
//  5 StallE=1 and FlushE=1 in the same cycle -> bubble (ValidE=0, RegWriteE=0, MemWriteE=0).
//  6 InstrD=32'hFC00_0000 and R-type funct 000001 -> IllegalE=1, ALUControlE=000, no writes;
//    mul funct 011000 with RD1D=6, RD2D=7 -> ALUControlE=101.

Source files
------------

// File: rtl/alu_ctrl_issue_stage.sv
// ID-side ALU decode and ID/EX pipeline register: decodes InstrD, builds SrcA/SrcB, registers controls.
// Latency: 1 cycle from InstrD/RD1D/RD2D to the E outputs; no combinational input-to-output path.
// Backpressure: StallE holds the ID/EX register, FlushE loads a bubble; RST > FlushE > StallE.
module alu_ctrl_issue_stage #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             StallE,
    input  logic             FlushE,
    input  logic [31:0]      InstrD,
    input  logic [WIDTH-1:0] RD1D,
    input  logic [WIDTH-1:0] RD2D,
    output logic [WIDTH-1:0] SrcAE,
    output logic [WIDTH-1:0] SrcBE,
    output logic [WIDTH-1:0] WriteDataE,
    output logic [2:0]       ALUControlE,
    output logic             RegWriteE,
    output logic             MemtoRegE,
    output logic             MemWriteE,
    output logic             BranchE,
    output logic [4:0]       WriteRegE,
    output logic             ValidE,
    output logic             IllegalE
);

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b100;
    localparam logic [2:0] ALU_MUL = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;

    logic [5:0]       op;
    logic [5:0]       funct;
    logic [WIDTH-1:0] imm;
    logic             unused_fields;

    assign op            = InstrD[31:26];
    assign funct         = InstrD[5:0];
    assign imm           = {{(WIDTH-16){InstrD[15]}}, InstrD[15:0]};
    // rs and shamt are not needed here: RD1D already carries rs, and no shifts are decoded.
    assign unused_fields = ^{InstrD[25:21], InstrD[10:6]};

    logic [2:0]       alu_ctrl;
    logic             reg_write;
    logic             mem_to_reg;
    logic             mem_write;
    logic             branch;
    logic             use_imm;
    logic             illegal;
    logic [WIDTH-1:0] src_b;
    logic [4:0]       write_reg;

    always_comb begin
        alu_ctrl   = ALU_AND;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        mem_write  = 1'b0;
        branch     = 1'b0;
        use_imm    = 1'b0;
        illegal    = 1'b0;
        unique case (op)
            6'b000000: begin
                reg_write = 1'b1;
                unique case (funct)
                    6'b100000: alu_ctrl = ALU_ADD;
                    6'b100010: alu_ctrl = ALU_SUB;
                    6'b100100: alu_ctrl = ALU_AND;
                    6'b100101: alu_ctrl = ALU_OR;
                    6'b101010: alu_ctrl = ALU_SLT;
                    6'b011000: alu_ctrl = ALU_MUL;
                    default: begin
                        reg_write = 1'b0;
                        illegal   = 1'b1;
                    end
                endcase
            end
            6'b100011: begin
                alu_ctrl   = ALU_ADD;
                use_imm    = 1'b1;
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            6'b101011: begin
                alu_ctrl  = ALU_ADD;
                use_imm   = 1'b1;
                mem_write = 1'b1;
            end
            6'b001000: begin
                alu_ctrl  = ALU_ADD;
                use_imm   = 1'b1;
                reg_write = 1'b1;
            end
            6'b000100: begin
                alu_ctrl = ALU_SUB;
                branch   = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        src_b     = use_imm ? imm : RD2D;
        write_reg = (op == 6'b000000) ? InstrD[15:11] : InstrD[20:16];
    end

    logic [WIDTH-1:0] src_a_q, src_a_d;
    logic [WIDTH-1:0] src_b_q, src_b_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [2:0]       alu_ctrl_q, alu_ctrl_d;
    logic             reg_write_q, reg_write_d;
    logic             mem_to_reg_q, mem_to_reg_d;
    logic             mem_write_q, mem_write_d;
    logic             branch_q, branch_d;
    logic [4:0]       write_reg_q, write_reg_d;
    logic             valid_q, valid_d;
    logic             illegal_q, illegal_d;

    always_comb begin
        src_a_d      = src_a_q;
        src_b_d      = src_b_q;
        wdata_d      = wdata_q;
        alu_ctrl_d   = alu_ctrl_q;
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        mem_write_d  = mem_write_q;
        branch_d     = branch_q;
        write_reg_d  = write_reg_q;
        valid_d      = valid_q;
        illegal_d    = illegal_q;
        if (FlushE) begin
            src_a_d      = '0;
            src_b_d      = '0;
            wdata_d      = '0;
            alu_ctrl_d   = '0;
            reg_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
            mem_write_d  = 1'b0;
            branch_d     = 1'b0;
            write_reg_d  = '0;
            valid_d      = 1'b0;
            illegal_d    = 1'b0;
        end else if (!StallE) begin
            src_a_d      = RD1D;
            src_b_d      = src_b;
            wdata_d      = RD2D;
            alu_ctrl_d   = alu_ctrl;
            reg_write_d  = reg_write;
            mem_to_reg_d = mem_to_reg;
            mem_write_d  = mem_write;
            branch_d     = branch;
            write_reg_d  = write_reg;
            valid_d      = 1'b1;
            illegal_d    = illegal;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            src_a_q      <= '0;
            src_b_q      <= '0;
            wdata_q      <= '0;
            alu_ctrl_q   <= '0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            mem_write_q  <= 1'b0;
            branch_q     <= 1'b0;
            write_reg_q  <= '0;
            valid_q      <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            src_a_q      <= src_a_d;
            src_b_q      <= src_b_d;
            wdata_q      <= wdata_d;
            alu_ctrl_q   <= alu_ctrl_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            mem_write_q  <= mem_write_d;
            branch_q     <= branch_d;
            write_reg_q  <= write_reg_d;
            valid_q      <= valid_d;
            illegal_q    <= illegal_d;
        end
    end

    assign SrcAE       = src_a_q;
    assign SrcBE       = src_b_q;
    assign WriteDataE  = wdata_q;
    assign ALUControlE = alu_ctrl_q;
    assign RegWriteE   = reg_write_q;
    assign MemtoRegE   = mem_to_reg_q;
    assign MemWriteE   = mem_write_q;
    assign BranchE     = branch_q;
    assign WriteRegE   = write_reg_q;
    assign ValidE      = valid_q;
    assign IllegalE    = illegal_q;

endmodule
